// File: rtl/gsim_sched.sv
// gsim_sched: sequencer for an iterative (Gauss-Seidel style) linear solver.
// It loads the right-hand side b, sweeps rows through an external PE with a
// fixed issue-to-writeback latency, and tracks the largest per-row update of
// each sweep. It repeats sweeps until that update is within tolerance or the
// sweep limit is hit, then streams the solution x out of the x buffer.
module gsim_sched #(
  parameter int unsigned N        = 16,
  parameter int unsigned MAX_ITER = 100,
  parameter int unsigned LAT      = 3,
  parameter logic [31:0] TOL      = 32'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  output logic        load_en,
  output logic [3:0]  load_idx,
  output logic        pe_issue,
  output logic [3:0]  pe_row,
  output logic        wb_en,
  output logic [3:0]  wb_row,
  input  logic [31:0] x_new,
  input  logic [31:0] x_old,
  output logic [3:0]  rd_idx,
  output logic        out_valid,
  output logic        busy,
  output logic [6:0]  iter_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic [3:0]  LAST_IDX   = 4'(N - 1);
  localparam logic [6:0]  ITER_LIMIT = 7'(MAX_ITER);
  localparam logic [32:0] TOL_W      = {1'b0, TOL};

  logic [2:0]  state_q, state_d;
  logic [3:0]  load_cnt_q, load_cnt_d;
  logic [3:0]  row_cnt_q, row_cnt_d;
  logic [6:0]  iter_q, iter_d;
  logic [32:0] max_delta_q, max_delta_d;
  logic        decide_q, decide_d;

  // Writeback pipeline: stage LAT-1 is the one presented as wb_en/wb_row.
  logic [LAT-1:0]      wb_vld_q, wb_vld_d;
  logic [LAT-1:0][3:0] wb_row_q, wb_row_d;

  logic signed [32:0] diff;
  logic [32:0]        abs_delta;
  logic [6:0]         iter_inc;
  logic               in_fill;

  assign in_fill  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign iter_inc = iter_q + 7'd1;

  // Output decode; reset gates load_en because in_en is a raw input.
  always_comb begin
    load_en   = in_en & in_fill & ~reset;
    load_idx  = load_cnt_q;
    pe_issue  = (state_q == S_CALC);
    pe_row    = pe_issue ? row_cnt_q : '0;
    wb_en     = wb_vld_q[LAT-1];
    wb_row    = wb_row_q[LAT-1];
    out_valid = (state_q == S_OUT);
    rd_idx    = out_valid ? row_cnt_q : '0;
    busy      = (state_q != S_IDLE);
    iter_cnt  = iter_q;
  end

  // Sign-extend both operands to 33 bits so the difference of any two
  // 32-bit values is exact, then take the magnitude.
  always_comb begin
    diff      = $signed({x_new[31], x_new}) - $signed({x_old[31], x_old});
    abs_delta = diff[32] ? 33'(-diff) : 33'(diff);
  end

  // Shift the issue strobe and row index toward the writeback end.
  always_comb begin
    wb_vld_d    = '0;
    wb_row_d    = '0;
    wb_vld_d[0] = pe_issue;
    wb_row_d[0] = pe_row;
    for (int unsigned i = 1; i < LAT; i++) begin
      wb_vld_d[i] = wb_vld_q[i-1];
      wb_row_d[i] = wb_row_q[i-1];
    end
  end

  // Sequencer: load b, sweep rows, drain, decide, stream results.
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    row_cnt_d   = row_cnt_q;
    iter_d      = iter_q;
    max_delta_d = max_delta_q;
    decide_d    = decide_q;

    if (wb_en && (abs_delta > max_delta_q)) begin
      max_delta_d = abs_delta;
    end

    case (state_q)
      S_IDLE: begin
        if (in_en) begin
          load_cnt_d = 4'd1;
          iter_d     = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_en) begin
          if (load_cnt_q == LAST_IDX) begin
            load_cnt_d  = '0;
            row_cnt_d   = '0;
            iter_d      = '0;
            max_delta_d = '0;
            state_d     = S_CALC;
          end else begin
            load_cnt_d = load_cnt_q + 4'd1;
          end
        end
      end
      S_CALC: begin
        if (row_cnt_q == LAST_IDX) begin
          row_cnt_d = '0;
          state_d   = S_DRAIN;
        end else begin
          row_cnt_d = row_cnt_q + 4'd1;
        end
      end
      S_DRAIN: begin
        // The last row's writeback lands in max_delta_q at the edge after
        // wb_en, so the decision is taken one cycle later.
        if (decide_q) begin
          decide_d = 1'b0;
          iter_d   = iter_inc;
          if (((iter_q != '0) && (max_delta_q <= TOL_W)) ||
              (iter_inc == ITER_LIMIT)) begin
            row_cnt_d = '0;
            state_d   = S_OUT;
          end else begin
            max_delta_d = '0;
            state_d     = S_CALC;
          end
        end else if (wb_en && (wb_row == LAST_IDX)) begin
          decide_d = 1'b1;
        end
      end
      S_OUT: begin
        if (row_cnt_q == LAST_IDX) begin
          row_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          row_cnt_d = row_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset also flushes any in-flight writebacks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      load_cnt_q  <= '0;
      row_cnt_q   <= '0;
      iter_q      <= '0;
      max_delta_q <= '0;
      decide_q    <= 1'b0;
      wb_vld_q    <= '0;
      wb_row_q    <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      row_cnt_q   <= row_cnt_d;
      iter_q      <= iter_d;
      max_delta_q <= max_delta_d;
      decide_q    <= decide_d;
      wb_vld_q    <= wb_vld_d;
      wb_row_q    <= wb_row_d;
    end
  end

endmodule

// File: tb/tb_gsim_sched.sv
// Testbench for gsim_sched. The reference model works on whole sweeps:
// from per-row (x_old, x_new) tables it computes how many sweeps the solver
// must run, and derives the expected output pattern of every cycle from
// the cycle offset alone.
module tb_gsim_sched;

  localparam int          N        = 16;
  localparam int          MAX_ITER = 100;
  localparam int          LAT      = 3;
  localparam logic [31:0] TOL      = 32'd16;
  localparam int          P        = N + LAT + 1;  // cycles per sweep

  logic        clk = 1'b0;
  logic        reset;
  logic        in_en;
  logic        load_en;
  logic [3:0]  load_idx;
  logic        pe_issue;
  logic [3:0]  pe_row;
  logic        wb_en;
  logic [3:0]  wb_row;
  logic [31:0] x_new;
  logic [31:0] x_old;
  logic [3:0]  rd_idx;
  logic        out_valid;
  logic        busy;
  logic [6:0]  iter_cnt;

  int checks    = 0;
  int failures  = 0;
  int prev_iter = 0;

  // PE answers per sweep (sweeps beyond 7 reuse row 7) and row.
  logic [31:0] xo_tab [8][N];
  logic [31:0] xn_tab [8][N];

  logic [27:0] obs;

  always #5 clk = ~clk;

  gsim_sched #(.N(N), .MAX_ITER(MAX_ITER), .LAT(LAT), .TOL(TOL)) dut (
    .clk(clk), .reset(reset), .in_en(in_en),
    .load_en(load_en), .load_idx(load_idx),
    .pe_issue(pe_issue), .pe_row(pe_row),
    .wb_en(wb_en), .wb_row(wb_row),
    .x_new(x_new), .x_old(x_old),
    .rd_idx(rd_idx), .out_valid(out_valid), .busy(busy),
    .iter_cnt(iter_cnt)
  );

  always_comb obs = {load_en, load_idx, pe_issue, pe_row, wb_en, wb_row,
                     out_valid, rd_idx, busy, iter_cnt};

  function automatic logic [27:0] mk(input logic le, input int li, input logic pi,
                                     input int pr, input logic we, input int wr,
                                     input logic ov, input int ri, input logic bz,
                                     input int it);
    return {le, 4'(li), pi, 4'(pr), we, 4'(wr), ov, 4'(ri), bz, 7'(it)};
  endfunction

  function automatic longint absdiff(input logic [31:0] xn, input logic [31:0] xo);
    longint d;
    d = longint'($signed(xn)) - longint'($signed(xo));
    return (d < 0) ? -d : d;
  endfunction

  // Number of sweeps the solver must complete for the current tables.
  function automatic int model_sweeps();
    for (int s = 0; s < MAX_ITER; s++) begin
      longint mx;
      int sc;
      mx = 0;
      sc = (s > 7) ? 7 : s;
      for (int r = 0; r < N; r++) begin
        if (absdiff(xn_tab[sc][r], xo_tab[sc][r]) > mx) mx = absdiff(xn_tab[sc][r], xo_tab[sc][r]);
      end
      if (((s > 0) && (mx <= longint'(TOL))) || (s + 1 == MAX_ITER)) return s + 1;
    end
    return MAX_ITER;
  endfunction

  task automatic fill_delta(input int d, input bit rand_sign);
    for (int s = 0; s < 8; s++) begin
      for (int r = 0; r < N; r++) begin
        logic signed [31:0] base;
        base = $signed($urandom() >> 2) - 32'sh2000_0000;
        xo_tab[s][r] = base;
        xn_tab[s][r] = (rand_sign && ($urandom_range(0, 1) == 1)) ? base - d : base + d;
      end
    end
  endtask

  task automatic fill_random();
    for (int s = 0; s < 8; s++) begin
      bit quiet;
      int hot;
      quiet = (s == 7) || ($urandom_range(0, 1) == 1);
      hot   = $urandom_range(0, N - 1);
      for (int r = 0; r < N; r++) begin
        logic signed [31:0] base;
        int d;
        base = $signed($urandom() >> 2) - 32'sh2000_0000;
        d    = (!quiet && r == hot) ? $urandom_range(17, 5000) : $urandom_range(0, 16);
        if ($urandom_range(0, 1) == 1) d = -d;
        xo_tab[s][r] = base;
        xn_tab[s][r] = base + d;
      end
    end
  endtask

  // Load N samples (gap_mode 0: continuous, 1: 5-cycle gap after sample 7,
  // 2: random gaps), then check every cycle through OUT and one IDLE cycle.
  // abort_at >= 0 returns at that CALC-relative cycle, right after the edge.
  task automatic run_system(input string tag, input int gap_mode, input int abort_at);
    int S, ld, gap_left, guard, s, j, sc;
    logic ie;
    logic [27:0] exp;
    S        = model_sweeps();
    ld       = 0;
    gap_left = 5;
    guard    = 0;
    while (ld < N) begin
      @(posedge clk); #1;
      ie = 1'b1;
      if (gap_mode == 1 && ld == 8 && gap_left > 0) begin
        ie = 1'b0;
        gap_left--;
      end else if (gap_mode == 2 && $urandom_range(0, 3) == 0) begin
        ie = 1'b0;
      end
      in_en = ie; x_new = $urandom(); x_old = $urandom();
      #1;
      exp = mk(ie, ld, 0, 0, 0, 0, 0, 0, ld > 0, (ld == 0) ? prev_iter : 0);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s_load ld=%0d got=%07h exp=%07h", tag, ld, obs, exp);
      end
      if (ie) ld++;
      guard++;
      if (guard > 200) begin
        checks++; failures++;
        $display("FAIL %s_load_timeout got=%0d samples exp=%0d", tag, ld, N);
        return;
      end
    end
    for (int k = 0; k <= S * P + N; k++) begin
      @(posedge clk); #1;
      if (k == abort_at) return;
      s  = k / P;
      j  = k % P;
      sc = (s > 7) ? 7 : s;
      in_en = (k == S * P + N) ? 1'b0 : 1'($urandom_range(0, 1));
      if (s < S && j >= LAT && j < N + LAT) begin
        x_old = xo_tab[sc][j-LAT];
        x_new = xn_tab[sc][j-LAT];
      end else begin
        x_old = $urandom();
        x_new = $urandom();
      end
      #1;
      if (s < S)
        exp = mk(0, 0, j < N, (j < N) ? j : 0, (j >= LAT && j < N + LAT),
                 (j >= LAT && j < N + LAT) ? j - LAT : 0, 0, 0, 1, s);
      else if (j < N)
        exp = mk(0, 0, 0, 0, 0, 0, 1, j, 1, S);
      else
        exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, S);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s_run k=%0d sweeps=%0d got=%07h exp=%07h", tag, k, S, obs, exp);
      end
    end
    prev_iter = S;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_en = 1'b1; x_new = $urandom(); x_old = $urandom();
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (obs !== 28'h0) begin
        failures++;
        $display("FAIL reset_hold i=%0d got=%07h exp=%07h", i, obs, 28'h0);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0; in_en = 1'b0;
    #1;
    checks++;
    if (obs !== 28'h0) begin
      failures++;
      $display("FAIL reset_release got=%07h exp=%07h", obs, 28'h0);
    end
    prev_iter = 0;
  endtask

  task automatic test_load_continuous();
    fill_delta(4, 0);
    run_system("load_cont", 0, -1);
  endtask

  task automatic test_load_gap();
    fill_random();
    run_system("load_gap", 1, -1);
  endtask

  task automatic test_max_iter();
    fill_delta(100, 1);
    run_system("max_iter", 0, -1);
  endtask

  task automatic test_delta17();
    int hot;
    fill_delta(0, 0);
    hot = $urandom_range(0, N - 1);
    xn_tab[1][hot] = xo_tab[1][hot] + 32'd17;
    run_system("delta17", 0, -1);
  endtask

  task automatic test_overflow();
    fill_delta(0, 0);
    xo_tab[1][9] = 32'h8000_0000; xn_tab[1][9] = 32'h7FFF_FFFF;
    xo_tab[2][3] = 32'h7FFF_FFFF; xn_tab[2][3] = 32'h8000_0000;
    run_system("overflow", 0, -1);
  endtask

  task automatic test_reset_mid_calc();
    fill_delta(4, 0);
    run_system("rst_mid", 0, 5);
    reset = 1'b1; in_en = 1'b1;
    #1;
    checks++;
    if (obs !== 28'h0) begin
      failures++;
      $display("FAIL rst_mid_during got=%07h exp=%07h", obs, 28'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0; in_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (obs !== 28'h0) begin
        failures++;
        $display("FAIL rst_mid_after i=%0d got=%07h exp=%07h", i, obs, 28'h0);
      end
      @(posedge clk); #1;
    end
    prev_iter = 0;
    fill_delta(4, 0);
    run_system("rst_mid_reload", 0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      fill_random();
      run_system("random", 2, -1);
    end
  endtask

  task automatic test_back_to_back();
    fill_delta(4, 1);
    run_system("b2b_a", 0, -1);
    fill_random();
    run_system("b2b_b", 0, -1);
  endtask

  initial begin
    reset = 1'b1; in_en = 1'b0; x_new = '0; x_old = '0;
    test_reset();
    test_load_continuous();
    test_load_gap();
    test_max_iter();
    test_delta17();
    test_overflow();
    test_reset_mid_calc();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gsim_sched.md
GSIM_SCHED -- requirements
Module: gsim_sched

Interface
REQ-001 The block SHALL use clock clk and reset reset, asynchronous, active-high.
REQ-002 Parameter N, default 16: unknowns per system (power of two, 4..16).
REQ-003 Parameter MAX_ITER, default 100: maximum number of sweeps.
REQ-004 Parameter LAT, default 3: PE issue-to-writeback latency in cycles (1..7).
REQ-005 Parameter TOL, default 32'd16: convergence threshold on |x_new - x_old|, 16.16 fixed point.
REQ-006 Ports SHALL be exactly:
- clk  in  1  clock
- reset  in  1  async active-high reset
- in_en  in  1  b sample valid this cycle
- load_en  out  1  write b sample into b buffer
- load_idx  out  4  b buffer write index
- pe_issue  out  1  PE computes row pe_row this cycle
- pe_row  out  4  row issued to PE
- wb_en  out  1  write PE result into x buffer
- wb_row  out  4  x buffer write index
- x_new  in  32  PE result, valid when wb_en=1
- x_old  in  32  previous x[wb_row], valid when wb_en=1
- rd_idx  out  4  x buffer read index for output
- out_valid  out  1  x_out (read at rd_idx) is valid
- busy  out  1  high in every state except IDLE
- iter_cnt  out  7  completed sweeps

Function
REQ-007 States SHALL be IDLE, LOAD, CALC, DRAIN, OUT.
REQ-008 load_en SHALL be combinational: in_en AND state in {IDLE, LOAD}; load_idx = load counter.
REQ-009 IDLE with in_en=1 SHALL capture sample 0 and enter LOAD; in_en=0 in LOAD SHALL hold the counter (no capture, no timeout).
REQ-010 Capture of sample N-1 SHALL transition to CALC next cycle, with iter_cnt=0 and max-delta register cleared.
REQ-011 in_en SHALL be ignored in CALC, DRAIN and OUT.
REQ-012 CALC SHALL assert pe_issue for exactly N consecutive cycles, pe_row = 0,1,...,N-1, then enter DRAIN.
REQ-013 wb_en/wb_row SHALL equal pe_issue/pe_row delayed by exactly LAT cycles, implemented as a shift pipeline.
REQ-014 DRAIN SHALL last until the writeback of row N-1 has occurred (wb_en for row N-1 seen); the decision SHALL be taken in the following cycle.
REQ-015 On each wb_en, delta = |x_new - x_old| SHALL be computed at 33-bit signed width with no overflow; the max-delta register SHALL hold the sweep maximum.
REQ-016 Decision: iter_cnt increments. Go to OUT if max-delta <= TOL or the new iter_cnt == MAX_ITER; otherwise clear max-delta and re-enter CALC.
REQ-017 Sweep 0 SHALL never terminate on tolerance (the initial x is zero and its delta is meaningless); only a MAX_ITER of 1 ends it.
REQ-018 OUT SHALL assert out_valid for N consecutive cycles with rd_idx = 0..N-1, then return to IDLE; busy SHALL drop in the same cycle out_valid drops.
REQ-019 iter_cnt SHALL hold its final value in IDLE until the next LOAD capture of sample 0, then clear.
REQ-020 pe_issue and wb_en SHALL never be high outside CALC/DRAIN. Writebacks that overlap the next sweep's issue are not possible, because DRAIN fully empties the pipeline.

Reset
REQ-021 reset SHALL immediately force state IDLE, all counters, max-delta and the LAT pipeline to 0.
REQ-022 During reset, load_en, pe_issue, wb_en, out_valid and busy SHALL be 0; rd_idx, pe_row, wb_row, load_idx and iter_cnt SHALL be 0.
REQ-023 Reset asserted mid-CALC or mid-OUT SHALL discard in-flight writebacks: no wb_en after reset release until a new load completes.

Verification
REQ-024 Load N=16 with in_en continuous -> load_idx 0..15, CALC entered on cycle 17, pe_issue for 16 cycles, first wb_en LAT=3 cycles after first issue.
REQ-025 in_en low for 5 cycles after sample 7 -> load_idx stays 8 and no load_en until in_en returns; CALC still starts after sample 15.
REQ-026 Model returns x_new = x_old + 4 (delta 4 <= TOL 16) on every row -> OUT after sweep 2, iter_cnt=2, out_valid high 16 cycles with rd_idx 0..15.
REQ-027 Model returns a constant delta of 100 -> OUT only when iter_cnt=100; one row with delta 17 and all others 0 -> no termination that sweep.
REQ-028 x_new = 32'h7FFFFFFF, x_old = 32'h80000000 -> delta computed without wrap, treated as > TOL.
REQ-029 reset pulsed at CALC cycle 5 -> all outputs 0 the next cycle, no wb_en afterwards, busy=0; a new 16-sample load then runs normally.
